ascon_hash_ctrl: RTL and testbench

Sequencer that runs Ascon-Hash256 (NIST SP 800-232 Section 5.1) on one `ascon_core` permutation engine. It drives the core's word-write/XOR port and permutation start, and takes in the message as a 64-bit little-endian block stream. It applies the padding rule and streams out the 256-bit digest as four 64-bit words. It sits between the system-level hash request interface and `ascon_core`, and is that core's only master.

---
 rtl/ascon_hash_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ascon_hash_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_hash_ctrl.sv
// Ascon-Hash256 sequencer: initialises, absorbs and squeezes through one
// external ascon_core permutation engine, producing a 256-bit digest as four words.
module ascon_hash_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        busy_o,
    input  logic        msg_valid_i,
    output logic        msg_ready_o,
    input  logic [63:0] msg_data_i,
    input  logic        msg_last_i,
    input  logic [3:0]  msg_bytes_i,
    output logic        hash_valid_o,
    input  logic        hash_ready_i,
    output logic [63:0] hash_data_o,
    output logic        hash_last_o,
    output logic        core_start_o,
    output logic        core_round_cfg_o,
    output logic [2:0]  core_word_sel_o,
    output logic [63:0] core_data_o,
    output logic        core_we_o,
    output logic        core_xor_o,
    input  logic [63:0] core_data_i,
    input  logic        core_ready_i
);

    localparam logic [63:0] IV = 64'h0000_0801_00CC_0002;

    typedef enum logic [2:0] {
        IDLE,
        INIT_WR,
        PERM_GO,
        PERM_WAIT,
        ABSORB,
        PAD,
        SQUEEZE
    } state_t;

    state_t      state, state_nx;
    state_t      after, after_nx;
    logic [2:0]  wcnt, wcnt_nx;
    logic [1:0]  sqcnt, sqcnt_nx;
    logic        wait_first;

    logic        last_full;
    logic [5:0]  pad_shift;
    logic [63:0] byte_mask;
    logic [63:0] pad_word;

    // A last block of 8 (or more) bytes needs a separate padding block.
    assign last_full = (msg_bytes_i >= 4'd8);
    assign pad_shift = {msg_bytes_i[2:0], 3'b000};
    assign byte_mask = (64'h1 << pad_shift) - 64'h1;
    assign pad_word  = (msg_data_i & byte_mask) | (64'h1 << pad_shift);

    assign core_round_cfg_o = 1'b1;
    assign busy_o           = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            after      <= IDLE;
            wcnt       <= 3'd0;
            sqcnt      <= 2'd0;
            wait_first <= 1'b0;
        end else begin
            state      <= state_nx;
            after      <= after_nx;
            wcnt       <= wcnt_nx;
            sqcnt      <= sqcnt_nx;
            // The core still reports ready during its start cycle, so skip one look.
            wait_first <= (state == PERM_GO);
        end
    end

    always_comb begin
        state_nx        = state;
        after_nx        = after;
        wcnt_nx         = wcnt;
        sqcnt_nx        = sqcnt;
        msg_ready_o     = 1'b0;
        hash_valid_o    = 1'b0;
        hash_data_o     = 64'h0;
        hash_last_o     = 1'b0;
        core_start_o    = 1'b0;
        core_word_sel_o = 3'd0;
        core_data_o     = 64'h0;
        core_we_o       = 1'b0;
        core_xor_o      = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx = INIT_WR;
                    wcnt_nx  = 3'd0;
                    sqcnt_nx = 2'd0;
                end
            end
            INIT_WR: begin
                core_we_o       = 1'b1;
                core_word_sel_o = wcnt;
                core_data_o     = (wcnt == 3'd0) ? IV : 64'h0;
                if (wcnt == 3'd4) begin
                    wcnt_nx  = 3'd0;
                    state_nx = PERM_GO;
                    after_nx = ABSORB;
                end else begin
                    wcnt_nx = wcnt + 3'd1;
                end
            end
            PERM_GO: begin
                core_start_o = 1'b1;
                state_nx     = PERM_WAIT;
            end
            PERM_WAIT: begin
                if (!wait_first && core_ready_i) begin
                    state_nx = after;
                end
            end
            ABSORB: begin
                msg_ready_o = 1'b1;
                core_xor_o  = 1'b1;
                core_we_o   = msg_valid_i;
                core_data_o = (msg_last_i && !last_full) ? pad_word : msg_data_i;
                if (msg_valid_i) begin
                    state_nx = PERM_GO;
                    if (!msg_last_i) begin
                        after_nx = ABSORB;
                    end else if (last_full) begin
                        after_nx = PAD;
                    end else begin
                        after_nx = SQUEEZE;
                    end
                end
            end
            PAD: begin
                core_we_o   = 1'b1;
                core_xor_o  = 1'b1;
                core_data_o = 64'h1;
                state_nx    = PERM_GO;
                after_nx    = SQUEEZE;
            end
            SQUEEZE: begin
                hash_valid_o = 1'b1;
                hash_data_o  = core_data_i;
                hash_last_o  = (sqcnt == 2'd3);
                if (hash_ready_i) begin
                    if (sqcnt == 2'd3) begin
                        sqcnt_nx = 2'd0;
                        state_nx = IDLE;
                    end else begin
                        sqcnt_nx = sqcnt + 2'd1;
                        state_nx = PERM_GO;
                        after_nx = SQUEEZE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// Bench for ascon_hash_ctrl: behavioural ascon_core model plus a software
// Ascon-Hash256 reference feeding an expected-digest scoreboard.
module tb_ascon_hash_ctrl;

    localparam logic [63:0] IV = 64'h0000_0801_00CC_0002;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        busy_o;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic [63:0] msg_data_i;
    logic        msg_last_i;
    logic [3:0]  msg_bytes_i;
    logic        hash_valid_o;
    logic        hash_ready_i;
    logic [63:0] hash_data_o;
    logic        hash_last_o;
    logic        core_start_o;
    logic        core_round_cfg_o;
    logic [2:0]  core_word_sel_o;
    logic [63:0] core_data_o;
    logic        core_we_o;
    logic        core_xor_o;
    logic [63:0] core_data_i;
    logic        core_ready_i;

    ascon_hash_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .busy_o           (busy_o),
        .msg_valid_i      (msg_valid_i),
        .msg_ready_o      (msg_ready_o),
        .msg_data_i       (msg_data_i),
        .msg_last_i       (msg_last_i),
        .msg_bytes_i      (msg_bytes_i),
        .hash_valid_o     (hash_valid_o),
        .hash_ready_i     (hash_ready_i),
        .hash_data_o      (hash_data_o),
        .hash_last_o      (hash_last_o),
        .core_start_o     (core_start_o),
        .core_round_cfg_o (core_round_cfg_o),
        .core_word_sel_o  (core_word_sel_o),
        .core_data_o      (core_data_o),
        .core_we_o        (core_we_o),
        .core_xor_o       (core_xor_o),
        .core_data_i      (core_data_i),
        .core_ready_i     (core_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_p12(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [7:0]  rc;
        {x4, x3, x2, x1, x0} = s;
        for (int r = 0; r < 12; r++) begin
            rc = 8'hF0 - 8'(15 * r);
            x2 = x2 ^ {56'h0, rc};
            x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
            x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
            x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
            x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
            x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
            x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
            x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        end
        return {x4, x3, x2, x1, x0};
    endfunction

    // Core model: ready drops the cycle after start and returns 14 cycles after it.
    logic [319:0] core_state;
    logic [3:0]   core_cnt;
    int           start_count = 0;
    int           bad_writes = 0;
    int           cycle = 0;

    assign core_ready_i = (core_cnt == 4'd0);
    assign core_data_i  = (core_word_sel_o < 3'd5) ? core_state[int'(core_word_sel_o) * 64 +: 64] : 64'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_state <= '0;
            core_cnt   <= 4'd0;
        end else if (core_cnt == 4'd0) begin
            if (core_we_o && core_word_sel_o < 3'd5) begin
                if (core_xor_o)
                    core_state[int'(core_word_sel_o) * 64 +: 64] <= core_state[int'(core_word_sel_o) * 64 +: 64] ^ core_data_o;
                else
                    core_state[int'(core_word_sel_o) * 64 +: 64] <= core_data_o;
            end
            if (core_start_o) core_cnt <= 4'd13;
        end else begin
            core_cnt <= core_cnt - 4'd1;
            if (core_cnt == 4'd1) core_state <= ascon_p12(core_state);
        end
    end

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (!rst) begin
            if (core_start_o) start_count <= start_count + 1;
            if (core_we_o && !core_ready_i) bad_writes <= bad_writes + 1;
        end
    end

    logic [7:0]  msg_bytes[$];
    logic [63:0] exp_q[$];
    logic        exp_last_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          hs_cycle = 0;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic bail(input string tag);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: observed no response expected one within 200 cycles", tag);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] stopping after timeout");
    endtask

    // Block b of the message, with bytes past the end filled with 0xFF junk.
    function automatic logic [63:0] block_word(input int b);
        logic [63:0] w;
        for (int i = 0; i < 8; i++)
            w[8*i +: 8] = (8*b + i < msg_bytes.size()) ? msg_bytes[8*b + i] : 8'hFF;
        return w;
    endfunction

    function automatic logic [63:0] padded_word(input int b, input int k);
        logic [63:0] w;
        w = 64'h1 << (8 * k);
        for (int i = 0; i < k; i++) w[8*i +: 8] = msg_bytes[8*b + i];
        return w;
    endfunction

    task automatic compute_ref();
        logic [319:0] s;
        int len, nfull;
        len   = msg_bytes.size();
        nfull = len / 8;
        s = ascon_p12({256'h0, IV});
        for (int b = 0; b < nfull; b++) begin
            s[63:0] = s[63:0] ^ block_word(b);
            s = ascon_p12(s);
        end
        s[63:0] = s[63:0] ^ padded_word(nfull, len % 8);
        s = ascon_p12(s);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(s[63:0]);
            exp_last_q.push_back(k == 3);
            if (k < 3) s = ascon_p12(s);
        end
    endtask

    task automatic push_kat();
        exp_q.push_back(64'h986B2F0F85E53B0B); exp_last_q.push_back(1'b0);
        exp_q.push_back(64'h649BA8DE8F9FF2CA); exp_last_q.push_back(1'b0);
        exp_q.push_back(64'h838F9B24AA70FAA1); exp_last_q.push_back(1'b0);
        exp_q.push_back(64'hB2924D30AA3BD59B); exp_last_q.push_back(1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ctl"},
                     {56'h0, busy_o, msg_ready_o, hash_valid_o, hash_last_o,
                      core_start_o, core_we_o, core_xor_o, core_round_cfg_o},
                     64'h01);
        check_output({tag, "_data"}, core_data_o | {61'h0, core_word_sel_o}, 64'h0);
    endtask

    task automatic wait_hash_valid(input string tag);
        int n;
        n = 0;
        while (!hash_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!hash_valid_o) bail(tag);
    endtask

    task automatic apply_stimulus(input bit hold);
        start_i = 1'b1;
        @(negedge clk);
        if (!hold) start_i = 1'b0;
        check_output("busy_after_start", {63'h0, busy_o}, 64'h1);
    endtask

    task automatic send_message(input int gap_max);
        int len, nblk, k, n;
        len  = msg_bytes.size();
        nblk = (len == 0) ? 1 : (len + 7) / 8;
        for (int b = 0; b < nblk; b++) begin
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            msg_valid_i = 1'b1;
            msg_data_i  = block_word(b);
            msg_last_i  = (b == nblk - 1);
            k           = msg_last_i ? len - 8*b : 8;
            msg_bytes_i = 4'(k);
            n = 0;
            while (!msg_ready_o && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!msg_ready_o) bail("msg_ready_timeout");
            if (msg_last_i) begin
                check_output("last_block_write", core_data_o, (k == 8) ? block_word(b) : padded_word(b, k));
                check_output("last_block_ctl", {59'h0, core_we_o, core_xor_o, core_word_sel_o}, 64'h18);
                hs_cycle = cycle;
            end
            @(negedge clk);
            msg_valid_i = 1'b0;
            msg_last_i  = 1'b0;
        end
    endtask

    task automatic get_words(input int n, input int stall, input bit check_first);
        logic [63:0] exp_d;
        logic        exp_l;
        for (int w = 0; w < n; w++) begin
            wait_hash_valid("hash_valid_timeout");
            if (w > 0 || check_first)
                check_output("hash_latency", 64'(cycle - hs_cycle), 64'd16);
            if (exp_q.size() == 0) begin
                exp_d = 64'h0;
                exp_l = 1'b0;
                check_output("scoreboard_empty", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_d = exp_q.pop_front();
                exp_l = exp_last_q.pop_front();
            end
            if (stall > 0) begin
                repeat (stall) @(negedge clk);
                check_output("hash_hold_valid", {63'h0, hash_valid_o}, 64'h1);
                check_output("hash_hold_data", hash_data_o, exp_d);
            end
            hash_ready_i = 1'b1;
            check_output("hash_data", hash_data_o, exp_d);
            check_output("hash_last", {63'h0, hash_last_o}, {63'h0, exp_l});
            hs_cycle = cycle;
            @(negedge clk);
            hash_ready_i = 1'b0;
        end
    endtask

    task automatic run_hash(input bit kat, input int gap_max, input int stall, input bit hold);
        int len, nblk, pad, s0;
        len  = msg_bytes.size();
        nblk = (len == 0) ? 1 : (len + 7) / 8;
        pad  = (len > 0 && len % 8 == 0) ? 1 : 0;
        if (kat) push_kat();
        else compute_ref();
        s0 = start_count;
        apply_stimulus(hold);
        send_message(gap_max);
        get_words(4, stall, pad == 0);
        check_output("perm_count", 64'(start_count - s0), 64'(1 + nblk + pad + 3));
        check_output("no_busy_writes", 64'(bad_writes), 64'd0);
        check_output("idle_after_hash", {63'h0, busy_o}, 64'h0);
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        msg_valid_i  = 1'b0;
        msg_data_i   = 64'h0;
        msg_last_i   = 1'b0;
        msg_bytes_i  = 4'd0;
        hash_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] empty message against published digest");
        msg_bytes.delete();
        run_hash(1'b1, 0, 0, 1'b0);

        $display("[TB] 8-byte message, padding block");
        msg_bytes.delete();
        for (int i = 0; i < 8; i++) msg_bytes.push_back(8'(i));
        run_hash(1'b0, 0, 0, 1'b0);

        $display("[TB] 3-byte message");
        msg_bytes.delete();
        for (int i = 0; i < 3; i++) msg_bytes.push_back(8'(i));
        run_hash(1'b0, 0, 0, 1'b0);

        $display("[TB] 21-byte message with backpressure");
        msg_bytes.delete();
        for (int i = 0; i < 21; i++) msg_bytes.push_back(8'($urandom));
        run_hash(1'b0, 10, 20, 1'b0);

        $display("[TB] 16-byte message with backpressure");
        msg_bytes.delete();
        for (int i = 0; i < 16; i++) msg_bytes.push_back(8'($urandom));
        run_hash(1'b0, 10, 20, 1'b0);

        $display("[TB] start held through two back-to-back hashes");
        msg_bytes.delete();
        for (int i = 0; i < 13; i++) msg_bytes.push_back(8'($urandom));
        run_hash(1'b0, 0, 0, 1'b1);
        run_hash(1'b0, 0, 0, 1'b0);

        $display("[TB] reset during permutation wait");
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (8) @(negedge clk);
        check_output("busy_before_reset", {63'h0, busy_o}, 64'h1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_perm_wait");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset during squeeze");
        msg_bytes.delete();
        push_kat();
        apply_stimulus(1'b0);
        send_message(0);
        get_words(1, 0, 1'b1);
        wait_hash_valid("squeeze_timeout");
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_squeeze");
        exp_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] empty message after reset");
        run_hash(1'b1, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
